// File: rtl/calab_sram_pkg.sv
// Shared types for the data-side SRAM-like bus responder.
package calab_sram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [2:0]  cnt;
    } resp_entry_t;

endpackage

// File: rtl/data_sram_slave_resp_fifo.sv
// In-order response queue; every stored entry counts down to its release cycle.
module resp_fifo
    import calab_sram_pkg::*;
#(
    parameter int QDEPTH  = 4,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     push_wr,
    input  logic [31:0]              push_rdata,
    input  logic                     pop,
    output logic                     head_valid,
    output logic                     head_wr,
    output logic [31:0]              head_rdata,
    output logic [2:0]               head_cnt,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    resp_entry_t   ent [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Idle slots also count down; harmless since they are reloaded on push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (push && wr_ptr == PW'(i))
                ent[i] <= '{wr: push_wr, rdata: push_rdata, cnt: 3'(LATENCY - 1)};
            else if (ent[i].cnt != 3'd0)
                ent[i].cnt <= ent[i].cnt - 3'd1;
        end
    end

    assign head_valid = (count != '0);
    assign head_wr    = ent[rd_ptr].wr;
    assign head_rdata = ent[rd_ptr].rdata;
    assign head_cnt   = ent[rd_ptr].cnt;

endmodule

// File: rtl/data_sram_slave.sv
// Data-side SRAM responder: word memory with byte writes, fixed-latency
// in-order responses through resp_fifo.
module data_sram_slave
    import calab_sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 1,
    parameter int QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        stall,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic [CW-1:0]         count;
    logic                  accept;
    logic [31:0]           push_rdata;
    logic                  head_valid;
    logic                  head_wr;
    logic [31:0]           head_rdata;
    logic [2:0]            head_cnt;
    logic                  unused_bits;

    // size is advisory only; wstrb decides which lanes land.
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

    assign idx               = data_sram_addr[DEPTH_LOG2+1:2];
    assign data_sram_addr_ok = data_sram_req & ~stall & ~reset & (count < CW'(QDEPTH));
    assign accept            = data_sram_req & data_sram_addr_ok;

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++)
                if (data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
    end

    // Read data is snapshotted at acceptance so later writes cannot disturb it.
    assign push_rdata = data_sram_wr ? 32'd0 : mem[idx];

    resp_fifo #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_wr    (data_sram_wr),
        .push_rdata (push_rdata),
        .pop        (data_sram_data_ok),
        .head_valid (head_valid),
        .head_wr    (head_wr),
        .head_rdata (head_rdata),
        .head_cnt   (head_cnt),
        .count      (count)
    );

    assign data_sram_data_ok = head_valid & (head_cnt == 3'd0) & ~reset;
    assign data_sram_rdata   = (data_sram_data_ok & ~head_wr) ? head_rdata : 32'd0;

endmodule

// File: tb/tb_data_sram_slave.sv
// Three responder configurations (L1/Q4, L3/Q4, L4/Q2) checked against a
// scoreboard of expected response data and response cycle.
module tb_data_sram_slave;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction
    function automatic int qd_of(input int d);
        return (d == 2) ? 2 : 4;
    endfunction

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0]       req = '1, wr = '0, stall = '0;
    logic [2:0]       addr_ok, data_ok;
    logic [2:0][1:0]  size = '{default: 2'd2};
    logic [2:0][3:0]  wstrb = '0;
    logic [2:0][31:0] addr = '0, wdata = '0, rdata;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_sram_slave #(
            .DEPTH_LOG2 (8),
            .LATENCY    (lat_of(g)),
            .QDEPTH     (qd_of(g))
        ) u_dut (
            .clk               (clk),
            .reset             (reset),
            .data_sram_req     (req[g]),
            .data_sram_wr      (wr[g]),
            .data_sram_size    (size[g]),
            .data_sram_wstrb   (wstrb[g]),
            .data_sram_addr    (addr[g]),
            .data_sram_wdata   (wdata[g]),
            .stall             (stall[g]),
            .data_sram_addr_ok (addr_ok[g]),
            .data_sram_data_ok (data_ok[g]),
            .data_sram_rdata   (rdata[g])
        );
    end

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    int          acc[$];
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    int          last_tries;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: data_ok must appear exactly on the scoreboard's due cycle.
    always @(negedge clk) begin
        bit e;
        for (int d = 0; d < 3; d++) begin
            e = (sb.size() > 0) && (sb[0].id == d) && (sb[0].due == cyc);
            chk($sformatf("data_ok%0d", d), {31'd0, data_ok[d]}, {31'd0, e});
            if (e) chk($sformatf("rdata%0d", d), rdata[d], sb[0].data);
            if ((sb.size() > 0) && (sb[0].id == d) && (sb[0].due <= cyc)) void'(sb.pop_front());
        end
    end

    task automatic set_req(input int d, input logic w, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] wd);
        req[d] = 1'b1; wr[d] = w; wstrb[d] = s; addr[d] = a; wdata[d] = wd;
    endtask

    // Waits (bounded) for addr_ok, then records the expected response.
    task automatic wait_acc(input int d);
        exp_t        e;
        int          key;
        logic [31:0] tmp;
        last_tries = 0;
        @(negedge clk);
        while (!addr_ok[d] && last_tries < 40) begin
            @(posedge clk); #1;
            @(negedge clk);
            last_tries++;
        end
        chk("accept", {31'd0, addr_ok[d]}, 32'd1);
        if (addr_ok[d]) begin
            tmp = addr[d];
            key = d * 1024 + int'(tmp[9:2]);
            if (!model.exists(key)) model[key] = 32'd0;
            acc.push_back(cyc + 1);
            e.id  = d;
            e.due = cyc + lat_of(d);
            if (wr[d]) begin
                e.data = 32'd0;
                tmp = model[key];
                for (int i = 0; i < 4; i++)
                    if (wstrb[d][i]) tmp[8*i +: 8] = wdata[d][8*i +: 8];
                model[key] = tmp;
            end else begin
                e.data = model[key];
            end
            sb.push_back(e);
        end
    endtask

    task automatic issue(input int d, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        set_req(d, w, s, a, wd);
        wait_acc(d);
    endtask

    task automatic idle(input int d, input int n);
        @(posedge clk); #1;
        req[d] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with requests held high: nothing may be accepted or returned.
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("rst_addr_ok", {31'd0, addr_ok[d]}, 32'd0);
                chk("rst_rdata", rdata[d], 32'd0);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; req = '0;
        repeat (2) @(posedge clk);

        // L1: full write then immediate read-back.
        acc.delete();
        issue(0, 1'b1, 4'hF, 32'h100, 32'h1234_5678);
        issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
        chk("l1_b2b", acc[1] - acc[0], 32'd1);
        issue(0, 1'b1, 4'b0010, 32'h101, 32'h0000_AB00);
        issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
        // Direct expectation on top of the model: 0x12345678 with byte 1 -> AB.
        chk("byte_model", model[32'h40], 32'h1234_AB78);
        issue(0, 1'b1, 4'h0, 32'h100, 32'hFFFF_FFFF);
        issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
        issue(0, 1'b1, 4'hF, 32'h600, 32'hDEAD_BEEF);
        issue(0, 1'b0, 4'h0, 32'h200, 32'h0);
        issue(0, 1'b1, 4'b1100, 32'h202, 32'h5A5A_0000);
        issue(0, 1'b0, 4'h0, 32'h200, 32'h0);
        idle(0, 3);

        // Stall holds off acceptance; the request lands on the first free cycle.
        @(posedge clk); #1;
        set_req(0, 1'b0, 4'h0, 32'h100, 32'h0);
        stall[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_aok", {31'd0, addr_ok[0]}, 32'd0);
            @(posedge clk); #1;
        end
        stall[0] = 1'b0;
        wait_acc(0);
        chk("stall_release", last_tries, 32'd0);
        idle(0, 3);

        // L3/Q4: six writes, then six back-to-back reads at full rate.
        for (int i = 0; i < 6; i++)
            issue(1, 1'b1, 4'hF, 32'h40 + 4 * i, 32'h1111_1111 * (i + 1) + 32'h0F);
        acc.delete();
        for (int i = 0; i < 6; i++)
            issue(1, 1'b0, 4'h0, 32'h40 + 4 * i, 32'h0);
        for (int i = 1; i < 6; i++)
            chk("l3_b2b", acc[i] - acc[0], i);
        idle(1, 8);

        // Reset with three reads in flight: they must vanish, memory must not.
        for (int i = 0; i < 3; i++)
            issue(1, 1'b0, 4'h0, 32'h40 + 4 * i, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midrst_aok", {31'd0, addr_ok[1]}, 32'd0);
            chk("midrst_rdata", rdata[1], 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0; req[1] = 1'b0;
        repeat (8) @(posedge clk);
        acc.delete();
        for (int i = 0; i < 4; i++)
            issue(1, 1'b0, 4'h0, 32'h40 + 4 * i, 32'h0);
        chk("post_rst_full", acc[3] - acc[0], 32'd3);
        idle(1, 8);

        // L4/Q2: throttled by addr_ok until the head pops.
        for (int i = 0; i < 6; i++)
            issue(2, 1'b1, 4'hF, 32'h10 + 4 * i, 32'hA0A0_0000 + i);
        idle(2, 6);
        acc.delete();
        for (int i = 0; i < 6; i++)
            issue(2, 1'b0, 4'h0, 32'h10 + 4 * i, 32'h0);
        chk("q2_second", acc[1] - acc[0], 32'd1);
        chk("q2_third", acc[2] - acc[0], 32'd5);
        idle(2, 12);

        chk("drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
